// File: rtl/gyro_frame_ctrl.sv
// Frame parser, zero-angle command sequencer and link watchdog for the MPU6050 UART link.
// Define GYRO_CKSUM_EN to verify frame checksums and count rejected frames in err_cnt.
module gyro_frame_ctrl #(
   parameter int INIT_WAIT_CYC = 1000000,
   parameter int TIMEOUT_CYC   = 5000000,
   parameter int GAP_CYC       = 1000
) (
   input  logic               clk0,
   input  logic               rst_n,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   input  logic               zero_req,
   output logic signed [15:0] roll,
   output logic signed [15:0] pitch,
   output logic signed [15:0] yaw,
   output logic               angle_valid,
   output logic               link_ok,
   output logic [7:0]         err_cnt
);

   typedef enum logic [1:0] {R_HUNT, R_TYPE, R_DATA, R_SUM} rx_state_t;
   typedef enum logic [1:0] {T_INIT, T_IDLE, T_SEND, T_GAP} tx_state_t;

   localparam int CNT_MAX = (INIT_WAIT_CYC > GAP_CYC) ? INIT_WAIT_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYC);

   function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    cmd_byte = 8'hFF;
         2'd1:    cmd_byte = 8'hAA;
         default: cmd_byte = 8'h52;
      endcase
   endfunction

   rx_state_t  rx_state, rx_state_n;
   logic [2:0] rx_idx;
   logic [7:0] frm_type;
   logic [7:0] dbyte [0:5];
   logic       sum_hit_p0;
   logic       good_p0;
   logic       bad_p0;

   // ---- stage p0: byte capture and checksum decision ----
   always_comb begin
      rx_state_n = rx_state;
      good_p0    = 1'b0;
      bad_p0     = 1'b0;
      if (rx_valid) begin
         case (rx_state)
            R_HUNT: if (rx_data == 8'h55) rx_state_n = R_TYPE;
            R_TYPE: rx_state_n = R_DATA;
            R_DATA: if (rx_idx == 3'd7) rx_state_n = R_SUM;
            R_SUM: begin
               rx_state_n = R_HUNT;
               if (sum_hit_p0) good_p0 = (frm_type == 8'h53);
               else            bad_p0  = 1'b1;
            end
            default: rx_state_n = R_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= R_HUNT;
         rx_idx   <= '0;
      end else begin
         rx_state <= rx_state_n;
         if (rx_valid && rx_state == R_TYPE)      rx_idx <= '0;
         else if (rx_valid && rx_state == R_DATA) rx_idx <= rx_idx + 3'd1;
      end
   end

   always_ff @(posedge clk0) begin
      if (rx_valid && rx_state == R_TYPE) frm_type <= rx_data;
      if (rx_valid && rx_state == R_DATA && rx_idx < 3'd6) dbyte[rx_idx] <= rx_data;
   end

`ifdef GYRO_CKSUM_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] sum_acc;

   // Running sum restarts on the sync byte, so it always includes 0x55.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         sum_acc <= '0;
      end else if (rx_valid) begin
         if (rx_state == R_HUNT) sum_acc <= 8'h55;
         else                    sum_acc <= sum_acc + rx_data;
      end
   end
   assign sum_hit_p0 = (rx_data == sum_acc);

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n)      err_cnt <= '0;
      else if (bad_p0) err_cnt <= sat_inc8(err_cnt);
   end
`else
   assign sum_hit_p0 = 1'b1;
   assign err_cnt    = '0;
`endif

   // ---- stage p1: published angles ----
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         roll        <= '0;
         pitch       <= '0;
         yaw         <= '0;
         angle_valid <= 1'b0;
      end else begin
         angle_valid <= good_p0;
         if (good_p0) begin
            roll  <= signed'({dbyte[1], dbyte[0]});
            pitch <= signed'({dbyte[3], dbyte[2]});
            yaw   <= signed'({dbyte[5], dbyte[4]});
         end
      end
   end

   logic [WD_W-1:0] wd_cnt;

   // A good frame takes priority over an expiring count.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt  <= '0;
         link_ok <= 1'b0;
      end else if (good_p0) begin
         wd_cnt  <= '0;
         link_ok <= 1'b1;
      end else if (wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_cnt == WD_MAX - WD_W'(1)) link_ok <= 1'b0;
      end else begin
         link_ok <= 1'b0;
      end
   end

   tx_state_t        tx_state, tx_state_n;
   logic [CNT_W-1:0] tx_cnt;
   logic [1:0]       tx_idx;
   logic             pending;
   logic             cnt_run;
   logic             cnt_done;
   logic             accept;
   logic             take;
   logic             init_done;

   always_comb begin
      tx_state_n = tx_state;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      take       = 1'b0;
      init_done  = 1'b0;
      cnt_run    = (tx_state == T_INIT) || (tx_state == T_GAP);
      cnt_done   = (tx_cnt == ((tx_state == T_INIT) ? INIT_LAST : GAP_LAST));
      accept     = 1'b0;
      case (tx_state)
         T_INIT: if (cnt_done) begin
            tx_state_n = T_IDLE;
            init_done  = 1'b1;
         end
         T_IDLE: if (pending) begin
            tx_state_n = T_SEND;
            take       = 1'b1;
         end
         T_SEND: begin
            tx_valid = 1'b1;
            tx_data  = cmd_byte(tx_idx);
            accept   = tx_ready;
            if (tx_ready && tx_idx == 2'd2) tx_state_n = T_GAP;
         end
         T_GAP: if (cnt_done) tx_state_n = T_IDLE;
         default: tx_state_n = T_INIT;
      endcase
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= T_INIT;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         pending  <= 1'b0;
      end else begin
         tx_state <= tx_state_n;
         if (tx_state_n != tx_state) tx_cnt <= '0;
         else if (cnt_run)           tx_cnt <= tx_cnt + CNT_W'(1);
         if (take)        tx_idx <= '0;
         else if (accept) tx_idx <= tx_idx + 2'd1;
         // A request arriving while a sequence starts queues one more.
         pending <= zero_req | init_done | (pending & ~take);
      end
   end

endmodule

// File: tb/tb_gyro_frame_ctrl.sv
// Directed + randomized bench for gyro_frame_ctrl with a byte-queue reference model.
module tb_gyro_frame_ctrl;
   localparam int INIT = 200;
   localparam int TOUT = 400;
   localparam int GAP  = 30;
`ifdef GYRO_CKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic        clk0 = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        zero_req;
   logic [15:0] roll, pitch, yaw;
   logic        angle_valid;
   logic        link_ok;
   logic [7:0]  err_cnt;

   gyro_frame_ctrl #(.INIT_WAIT_CYC(INIT), .TIMEOUT_CYC(TOUT), .GAP_CYC(GAP)) dut (
      .clk0(clk0), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .zero_req(zero_req),
      .roll(roll), .pitch(pitch), .yaw(yaw), .angle_valid(angle_valid),
      .link_ok(link_ok), .err_cnt(err_cnt)
   );

   always #5 clk0 = ~clk0;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0]  m_q[$];
   logic [15:0] m_roll, m_pitch, m_yaw;
   logic        m_av, m_link, m_good_now;
   int          m_err, m_since;

   logic [7:0]  acc_b[$];
   int          acc_t[$];
   int          cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_roll = '0; m_pitch = '0; m_yaw = '0;
      m_av = 1'b0; m_link = 1'b0; m_good_now = 1'b0;
      m_err = 0; m_since = TOUT;
   endtask

   task automatic model_byte(input logic [7:0] b);
      int s;
      bit ok;
      if (m_q.size() == 0) begin
         if (b == 8'h55) m_q.push_back(b);
      end else begin
         m_q.push_back(b);
         if (m_q.size() == 11) begin
            s = 0;
            for (int i = 0; i < 10; i++) s += m_q[i];
            ok = CK_EN ? ((s % 256) == m_q[10]) : 1'b1;
            if (ok && m_q[1] == 8'h53) begin
               m_roll  = {m_q[3], m_q[2]};
               m_pitch = {m_q[5], m_q[4]};
               m_yaw   = {m_q[7], m_q[6]};
               m_av = 1'b1;
               m_good_now = 1'b1;
            end else if (!ok && m_err < 255) begin
               m_err++;
            end
            m_q.delete();
         end
      end
   endtask

   // One clock; samples land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk0);
      #1;
      cyc++;
      if (m_good_now) begin
         m_since = 0;
         m_link  = 1'b1;
      end else begin
         if (m_since < TOUT) m_since++;
         if (m_since >= TOUT) m_link = 1'b0;
      end
      m_good_now = 1'b0;
   endtask

   task automatic check_rx();
      chk("angle_valid", angle_valid, m_av);
      chk("roll", roll, m_roll);
      chk("pitch", pitch, m_pitch);
      chk("yaw", yaw, m_yaw);
      chk("err_cnt", err_cnt, m_err);
      chk("link_ok", link_ok, m_link);
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      rx_data = b; rx_valid = 1'b1;
      m_av = 1'b0;
      model_byte(b);
      tick();
      rx_valid = 1'b0;
      check_rx();
      m_av = 1'b0;
      for (int i = 0; i < idle; i++) begin
         tick();
         check_rx();
      end
   endtask

   task automatic send_frame(input logic [7:0] typ, input logic [63:0] d, input bit bad, input bit rnd_gap);
      logic [7:0] s;
      s = 8'h55 + typ;
      send_byte(8'h55, rnd_gap ? $urandom_range(0, 2) : 0);
      send_byte(typ, rnd_gap ? $urandom_range(0, 2) : 0);
      for (int i = 0; i < 8; i++) begin
         s = s + d[8*i +: 8];
         send_byte(d[8*i +: 8], rnd_gap ? $urandom_range(0, 2) : 0);
      end
      send_byte(bad ? s + 8'd1 : s, 0);
   endtask

   // Run ncyc clocks recording every byte the UART side accepts.
   task automatic tx_window(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         if (tx_valid && tx_ready) begin
            acc_b.push_back(tx_data);
            acc_t.push_back(cyc);
         end
         tick();
      end
   endtask

   initial begin
      int waited;
      int idle_cnt;
      logic [63:0] d;

      rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; zero_req = 1'b0;
      model_reset();
      #12;
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_link_ok", link_ok, 1'b0);
      chk("rst_angle_valid", angle_valid, 1'b0);
      chk("rst_roll", roll, 16'h0);
      chk("rst_pitch", pitch, 16'h0);
      chk("rst_yaw", yaw, 16'h0);
      chk("rst_err_cnt", err_cnt, 8'h0);
      @(posedge clk0); #1;
      rst_n = 1'b1;

      // power-up zero command, held off by tx_ready=0
      waited = 0;
      while (!tx_valid && waited < INIT + 20) begin
         tick();
         waited++;
      end
      chk("init_tx_seen", tx_valid, 1'b1);
      chk("init_not_early", waited >= INIT, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_tx_valid", tx_valid, 1'b1);
         chk("hold_tx_data", tx_data, 8'hFF);
      end
      tx_ready = 1'b1;
      acc_b.delete(); acc_t.delete();
      waited = 0;
      while (acc_b.size() < 3 && waited < 20) begin
         tx_window(1);
         waited++;
      end
      chk("init_seq_len", acc_b.size(), 3);
      if (acc_b.size() == 3) begin
         chk("init_b0", acc_b[0], 8'hFF);
         chk("init_b1", acc_b[1], 8'hAA);
         chk("init_b2", acc_b[2], 8'h52);
      end
      idle_cnt = 0;
      for (int i = 0; i < GAP + 5; i++) begin
         if (!tx_valid) idle_cnt++;
         tick();
      end
      chk("init_gap_idle", idle_cnt, GAP + 5);

      // directed frames
      send_frame(8'h53, 64'h0000_0000_0030_0020_0010 >> 0, 1'b0, 1'b0);
      chk("dir_roll", roll, 16'h0010);
      chk("dir_pitch", pitch, 16'h0020);
      chk("dir_yaw", yaw, 16'h0030);
      chk("dir_link", link_ok, 1'b1);
      send_frame(8'h53, 64'h0000_0000_0030_0020_0010, 1'b1, 1'b0);
      chk("bad_err1", err_cnt, CK_EN ? 8'd1 : 8'd0);
      for (int f = 0; f < 300; f++) send_frame(8'h53, 64'h0000_0000_0030_0020_0010, 1'b1, 1'b0);
      chk("err_saturate", err_cnt, CK_EN ? 8'd255 : 8'd0);
      send_byte(8'h12, 0);
      send_frame(8'h51, 64'h0807_0605_0403_0201, 1'b0, 1'b0);
      chk("type51_dropped", roll, 16'h0010);
      send_frame(8'h53, 64'h1122_3344_5566_8899, 1'b0, 1'b0);
      chk("after51_roll", roll, 16'h8899);
      chk("after51_yaw", yaw, 16'h3344);

      // randomized traffic with junk and gaps, including 0x55 inside payloads
      for (int f = 0; f < 40; f++) begin
         for (int j = $urandom_range(0, 2); j > 0; j--) send_byte(8'($urandom_range(0, 255)), 0);
         d = {$urandom(), $urandom()};
         if (f % 5 == 0) d[15:8] = 8'h55;
         send_frame(($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h53,
                    d, $urandom_range(0, 3) == 0, 1'b1);
      end
      // flush any partial frame the junk may have started
      for (int j = 0; j < 11 && m_q.size() != 0; j++) send_byte(8'h00, 0);

      // watchdog
      send_frame(8'h53, 64'h0000_0000_0003_0002_0001, 1'b0, 1'b0);
      chk("wd_link_up", link_ok, 1'b1);
      for (int i = 0; i < TOUT - 1; i++) begin
         tick();
         check_rx();
      end
      chk("wd_before_expiry", link_ok, 1'b1);
      tick();
      chk("wd_expired", link_ok, 1'b0);
      send_frame(8'h53, 64'h0000_0000_0006_0005_0004, 1'b0, 1'b0);
      chk("wd_recovered", link_ok, 1'b1);

      // three requests during one sequence merge into a single extra sequence
      tx_ready = 1'b0;
      zero_req = 1'b1; tick(); zero_req = 1'b0;
      waited = 0;
      while (!tx_valid && waited < 10) begin
         tick();
         waited++;
      end
      chk("zr_start", tx_valid, 1'b1);
      for (int k = 0; k < 3; k++) begin
         zero_req = 1'b1; tick(); zero_req = 1'b0; tick();
      end
      tx_ready = 1'b1;
      acc_b.delete(); acc_t.delete();
      tx_window(3 * GAP + 60);
      chk("zr_count", acc_b.size(), 6);
      if (acc_b.size() == 6) begin
         chk("zr_b0", acc_b[0], 8'hFF);
         chk("zr_b1", acc_b[1], 8'hAA);
         chk("zr_b2", acc_b[2], 8'h52);
         chk("zr_b3", acc_b[3], 8'hFF);
         chk("zr_b4", acc_b[4], 8'hAA);
         chk("zr_b5", acc_b[5], 8'h52);
         chk("zr_gap", (acc_t[3] - acc_t[2]) > GAP, 1'b1);
      end

      // asynchronous reset in the middle of a command
      tx_ready = 1'b0;
      zero_req = 1'b1; tick(); zero_req = 1'b0;
      waited = 0;
      while (!tx_valid && waited < 10) begin
         tick();
         waited++;
      end
      chk("mid_send", tx_valid, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_tx_valid", tx_valid, 1'b0);
      chk("async_tx_data", tx_data, 8'h00);
      chk("async_link", link_ok, 1'b0);
      chk("async_roll", roll, 16'h0);
      chk("async_pitch", pitch, 16'h0);
      chk("async_yaw", yaw, 16'h0);
      chk("async_err", err_cnt, 8'h0);
      chk("async_av", angle_valid, 1'b0);
      @(posedge clk0); #1;
      rst_n = 1'b1;
      model_reset();
      send_frame(8'h53, 64'h0000_0000_0C00_0B00_0A00, 1'b0, 1'b0);
      chk("post_rst_roll", roll, 16'h0A00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/gyro_frame_ctrl.md
Name: gyro_frame_ctrl

Overview:
Controller sitting between the 9600-baud byte-level UART (rx byte strobe in, tx byte handshake out) and the MPU6050 attitude consumers.
- Hunts and parses 11-byte sensor frames, verifies checksums and publishes roll/pitch/yaw from angle frames (type 0x53).
- Sequences the sensor's zero-angle command (FF AA 52) on request and once after power-up.
- Runs a link watchdog so downstream logic knows when the angles are stale.

Parameters:
INIT_WAIT_CYC, 1000000, clk0 cycles after reset before the automatic power-up zero command is sent
TIMEOUT_CYC, 5000000, clk0 cycles without a good angle frame before link_ok drops
GAP_CYC, 1000, idle clk0 cycles enforced after each command sequence completes

Ports:
clk0  in  1  system clock; all logic on its rising edge
rst_n  in  1  reset, asynchronous assert, active-low
rx_data  in  8  received byte from UART
rx_valid  in  1  one-cycle strobe; rx_data is valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  UART transmitter can accept a byte
zero_req  in  1  one-cycle pulse requesting a zero-angle command
roll  out  16  latest roll, {D1,D0}
pitch  out  16  latest pitch, {D3,D2}
yaw  out  16  latest yaw, {D5,D4}
angle_valid  out  1  one-cycle pulse when roll/pitch/yaw update
link_ok  out  1  good angle frame received within TIMEOUT_CYC
err_cnt  out  8  count of rejected frames, saturating at 255

Behaviour:
- Clock and reset: one clock, clk0; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 (tx_valid=0, link_ok=0, err_cnt=0, angles=0); both FSMs return to their initial state.
- Reset mid-operation: any in-flight frame or command is discarded. tx_valid drops asynchronously.

RX parser FSM (advances only on rx_valid):
- R_HUNT: byte 0x55 -> R_TYPE; any other byte is ignored.
- R_TYPE: latch type -> R_DATA with idx=0.
- R_DATA: store D[idx]; idx 0..7. After idx=7 -> R_SUM.
- R_SUM: compare the byte with the 8-bit wrapped sum of bytes 0x55, type and D0..D7.
  - Match and type==0x53: roll/pitch/yaw and angle_valid (1 cycle) are registered on the cycle after the rx_valid carrying the checksum byte.
  - Match and any other type: frame silently dropped.
  - Mismatch: err_cnt +1 (saturating).
  - In all cases -> R_HUNT.
- 0x55 arriving inside R_TYPE, R_DATA or R_SUM is treated as data, not a resync.

Watchdog:
- Counter clears on every good angle frame and otherwise increments, saturating at TIMEOUT_CYC.
- link_ok=1 from the good-frame update cycle onward; link_ok=0 when the counter reaches TIMEOUT_CYC.
- Good frame in the same cycle as timeout: the good frame wins (link_ok stays 1).

TX sequencer FSM:
- T_INIT: counts INIT_WAIT_CYC, then sets pending.
- T_IDLE: if pending -> T_SEND with idx=0 and pending cleared.
- T_SEND: tx_data = {FF,AA,52}[idx] with tx_valid=1. A byte is accepted when tx_valid && tx_ready; on acceptance idx++. After the 0x52 byte is accepted -> T_GAP.
- T_GAP: counts GAP_CYC -> T_IDLE.
- tx_data must be stable while tx_valid=1 and tx_ready=0.
- zero_req in any state sets pending. Multiple requests while pending or busy merge into one further sequence.
- RX parsing runs concurrently with TX and is unaffected by it.

Optional Feature:
- Macro GYRO_CKSUM_EN.
- Defined: checksum is compared as above.
- Undefined: the checksum byte is consumed without comparison, every complete frame is accepted, and err_cnt is tied to 0.

Test Plan:
- Reset then feed 55 53 10 00 20 00 30 00 00 00 08 -> one cycle after the last strobe: roll=0x0010, pitch=0x0020, yaw=0x0030, angle_valid pulse, link_ok=1, err_cnt=0.
- Same frame with checksum 0x09 -> angles unchanged, no angle_valid, err_cnt=1. Then 300 bad frames -> err_cnt=255 (saturated).
- Feed 12 55 51 + 8 data bytes + correct checksum, then a 0x53 frame -> 0x51 frame dropped, only the 0x53 frame updates outputs.
- Hold tx_ready=0 for 20 cycles after INIT_WAIT_CYC -> tx_valid=1 with tx_data=FF stable. Release tx_ready -> bytes FF, AA, 52 in order, then tx_valid=0 for at least GAP_CYC cycles.
- Pulse zero_req 3 times during T_SEND -> exactly one further FF AA 52 sequence after T_GAP.
- After a good frame, no further frames for TIMEOUT_CYC cycles -> link_ok=0. Next good frame -> link_ok=1. Assert rst_n=0 mid-T_SEND -> tx_valid=0 immediately and all outputs 0.
